// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, exception redirect and a circular
// hardware return-address stack feeding RAS pops back into the fetch PC.
module pc_unit #(
  parameter int unsigned N            = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned RAS_AW       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         exc,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         jump,
  input  logic         call,
  input  logic [N-1:0] jump_target,
  input  logic         ret,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_err,
  output logic         misaligned
);

  localparam int unsigned DEPTH  = 2 ** RAS_AW;
  localparam logic [N-1:0] RST_PC = N'(RESET_VECTOR);
  localparam logic [N-1:0] EXC_PC = N'(EXC_VECTOR);
  localparam logic [RAS_AW:0] CNT_FULL = (RAS_AW + 1)'(DEPTH);
  localparam logic [RAS_AW:0] CNT_ONE  = (RAS_AW + 1)'(1);

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_EXC,
    SEL_SEQ,
    SEL_RAS,
    SEL_JUMP,
    SEL_BRANCH
  } pc_sel_e;

  pc_sel_e            sel;
  logic [N-1:0]       ras_mem [DEPTH];
  logic [RAS_AW-1:0]  top, top_next, wr_idx;
  logic [RAS_AW:0]    count, count_next;
  logic               err_next, mis_next, wr_en;
  logic [N-1:0]       pc_next, ras_top;

  assign pc_plus4  = pc + N'(4);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_FULL);
  assign ras_top   = ras_mem[top];

  always_comb begin
    sel        = SEL_SEQ;
    top_next   = top;
    count_next = count;
    err_next   = ras_err;
    mis_next   = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = top + 1'b1;
    if (exc) begin
      sel        = SEL_EXC;
      count_next = '0;
      err_next   = 1'b0;
    end else if (!ena) begin
      sel = SEL_HOLD;
    end else if (ret) begin
      if (!ras_empty) begin
        sel = SEL_RAS;
        // call+ret swaps the top entry in place instead of pop-then-push
        if (call) begin
          wr_en  = 1'b1;
          wr_idx = top;
        end else begin
          top_next   = top - 1'b1;
          count_next = count - 1'b1;
        end
      end else begin
        sel      = SEL_SEQ;
        err_next = 1'b1;
        if (call) begin
          wr_en      = 1'b1;
          top_next   = top + 1'b1;
          count_next = CNT_ONE;
        end
      end
    end else if (call) begin
      sel      = SEL_JUMP;
      wr_en    = 1'b1;
      top_next = top + 1'b1;
      mis_next = |jump_target[1:0];
      if (ras_full) err_next = 1'b1;
      else          count_next = count + 1'b1;
    end else if (jump) begin
      sel      = SEL_JUMP;
      mis_next = |jump_target[1:0];
    end else if (branch_taken) begin
      sel      = SEL_BRANCH;
      mis_next = |branch_target[1:0];
    end
  end

  always_comb begin
    pc_next = pc_plus4;
    case (sel)
      SEL_HOLD:   pc_next = pc;
      SEL_EXC:    pc_next = EXC_PC;
      SEL_RAS:    pc_next = {ras_top[N-1:2], 2'b00};
      SEL_JUMP:   pc_next = {jump_target[N-1:2], 2'b00};
      SEL_BRANCH: pc_next = {branch_target[N-1:2], 2'b00};
      default:    pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RST_PC;
      top        <= '0;
      count      <= '0;
      ras_err    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      pc         <= pc_next;
      top        <= top_next;
      count      <= count_next;
      ras_err    <= err_next;
      misaligned <= mis_next;
    end
  end

  // Storage has no reset; only count/top define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) ras_mem[wr_idx] <= pc_plus4;
  end

endmodule
